// File: rtl/mem_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_responder
// Description : Arbitrates an instruction port and a data port onto a single
//               backing-memory port. Only one transaction is in flight at a
//               time. Fields are latched at grant and the CPU response pulse
//               lasts one cycle.
// Config      : MEM_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests
//               alternate. When undefined, dmem has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_read,
    input  logic [15:0] imem_address,
    output logic [15:0] imem_rdata,
    output logic        imem_resp,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [15:0] dmem_address,
    input  logic [15:0] dmem_wdata,
    input  logic [1:0]  dmem_byte_enable,
    output logic [15:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_BUSY = 3'd1,
        ST_D_BUSY = 3'd2,
        ST_I_RESP = 3'd3,
        ST_D_RESP = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_write;
    logic        r_alive;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [1:0]  r_be;
    logic [15:0] r_imem_rdata;
    logic [15:0] r_dmem_rdata;

    logic        w_dmem_req;
    logic        w_any_req;
    logic        w_grant_d;
    logic        w_busy;
    logic        w_owner_req;

    // A simultaneous read and write is handled as a write.
    assign w_dmem_req = dmem_read | dmem_write;
    assign w_any_req  = imem_read | w_dmem_req;
    assign w_busy     = (r_state == ST_I_BUSY) || (r_state == ST_D_BUSY);
    // This is the live request of the port that owns the current transaction.
    assign w_owner_req = ((r_state == ST_I_BUSY) || (r_state == ST_I_RESP)) ?
                         imem_read : w_dmem_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_d;

    // On a conflict, grant the port that was not served last.
    assign w_grant_d = w_dmem_req && (!imem_read || !r_last_d);

    // Record which port won each grant. The reset value points at imem.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = w_dmem_req;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Compute next state and all handshake outputs. pmem fields are gated to
    // zero outside the busy states.
    always_comb begin
        w_state_next     = r_state;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = 16'h0000;
        pmem_wdata       = 16'h0000;
        pmem_byte_enable = 2'b00;
        imem_resp        = 1'b0;
        dmem_resp        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_next = ST_D_BUSY;
                end else if (imem_read) begin
                    w_state_next = ST_I_BUSY;
                end
            end
            ST_I_BUSY, ST_D_BUSY: begin
                pmem_read        = ~r_write;
                pmem_write       = r_write;
                pmem_address     = r_addr;
                pmem_wdata       = r_wdata;
                pmem_byte_enable = r_be;
                if (pmem_resp) begin
                    w_state_next = (r_state == ST_I_BUSY) ? ST_I_RESP : ST_D_RESP;
                end
            end
            ST_I_RESP: begin
                imem_resp    = r_alive & w_owner_req;
                w_state_next = ST_IDLE;
            end
            ST_D_RESP: begin
                dmem_resp    = r_alive & w_owner_req;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Latch request fields at grant, track flushes, and capture read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write      <= 1'b0;
            r_alive      <= 1'b0;
            r_addr       <= 16'h0000;
            r_wdata      <= 16'h0000;
            r_be         <= 2'b00;
            r_imem_rdata <= 16'h0000;
            r_dmem_rdata <= 16'h0000;
        end else begin
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_alive <= 1'b1;
                if (w_grant_d) begin
                    r_write <= dmem_write;
                    r_addr  <= dmem_address;
                    r_wdata <= dmem_wdata;
                    r_be    <= dmem_write ? dmem_byte_enable : 2'b11;
                end else begin
                    r_write <= 1'b0;
                    r_addr  <= imem_address;
                    r_wdata <= 16'h0000;
                    r_be    <= 2'b11;
                end
            end
            if (w_busy && !w_owner_req) begin
                r_alive <= 1'b0;
            end
            if ((r_state == ST_I_BUSY) && pmem_resp) begin
                r_imem_rdata <= pmem_rdata;
            end
            if ((r_state == ST_D_BUSY) && pmem_resp) begin
                r_dmem_rdata <= pmem_rdata;
            end
        end
    end

    assign imem_rdata = r_imem_rdata;
    assign dmem_rdata = r_dmem_rdata;

endmodule
`default_nettype wire
